// File: rtl/cen_synth_pkg.sv
// Shared constants and step-value helper for the clock-enable synthesiser.
// cen_step() builds INIT_STEP entries at elaboration time.
package cen_synth_pkg;

    localparam int CEN_ACC_W = 32;

    // Rounded f_out * 2^acc_w / f_ref. The 128-bit intermediate keeps 48-bit accumulators with GHz rates exact.
    function automatic logic [63:0] cen_step(
        input longint unsigned f_ref_hz,
        input longint unsigned f_out_hz,
        input int unsigned     acc_w
    );
        logic [127:0] w_num;
        w_num = ({64'd0, f_out_hz} << acc_w) + {65'd0, f_ref_hz[63:1]};
        return 64'(w_num / {64'd0, f_ref_hz});
    endfunction

endpackage

// File: rtl/cen_nco.sv
// One NCO channel: ACC_W-bit phase accumulator, carry out as a 1-cycle ce, MSB as outclk.
// One-cycle latency from step to registered outputs; cleared and held at zero whenever not running.
module cen_nco #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [ACC_W-1:0] step,
    output logic             ce,
    output logic             outclk
);

    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic             r_outclk;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, step};

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            r_acc    <= '0;
            r_ce     <= 1'b0;
            r_outclk <= 1'b0;
        end else begin
            r_acc    <= w_sum[ACC_W-1:0];
            r_ce     <= w_sum[ACC_W];
            r_outclk <= w_sum[ACC_W-1];
        end
    end

    assign ce     = r_ce;
    assign outclk = r_outclk;

endmodule

// File: rtl/cen_synth.sv
// Multi-channel fractional clock-enable synthesiser with run-time step updates and a lock indication.
// Outputs registered; cfg_ready drops for LOCK_CYCLES after each accepted reconfiguration.
module cen_synth
    import cen_synth_pkg::*;
#(
    parameter int                          CHANNELS    = 2,
    parameter int                          ACC_W       = CEN_ACC_W,
    parameter int                          LOCK_CYCLES = 16,
    parameter logic [CHANNELS*ACC_W-1:0]   INIT_STEP   = {CHANNELS{32'h8000_0000}},
    localparam int                         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]    cfg_step,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] outclk,
    output logic                locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [ACC_W-1:0]    r_step [CHANNELS];
    logic [CNT_W-1:0]    r_lock_cnt;
    logic                r_locked;
    logic [CHANNELS-1:0] w_hit;
    logic                w_accept;
    logic                w_relock;

    // Out-of-range channel indices match no w_hit bit, so they are accepted without any effect.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_hit
        assign w_hit[g] = (cfg_chan == CH_W'(g));
    end

    assign w_accept = cfg_valid & r_locked;
    assign w_relock = w_accept & (|w_hit);

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_step[i] <= INIT_STEP[i*ACC_W +: ACC_W];
            end
            r_lock_cnt <= CNT_W'(LOCK_CYCLES);
            r_locked   <= 1'b0;
        end else if (w_relock) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_hit[i]) begin
                    r_step[i] <= cfg_step;
                end
            end
            r_lock_cnt <= CNT_W'(LOCK_CYCLES);
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt - CNT_W'(1);
            r_locked   <= (r_lock_cnt == CNT_W'(1));
        end
    end

    // Clearing every channel on a relock keeps all channels phase-aligned to a common origin.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        cen_nco #(
            .ACC_W (ACC_W)
        ) u_nco (
            .clk    (refclk),
            .rst    (rst),
            .clear  (w_relock),
            .run    (r_locked),
            .step   (r_step[g]),
            .ce     (ce[g]),
            .outclk (outclk[g])
        );
    end

    assign locked    = r_locked;
    assign cfg_ready = r_locked;

endmodule

// File: tb/tb_cen_synth.sv
// Scoreboard bench for cen_synth: stimulus queues expectations by cycle, a negedge monitor logs outputs and checks them.
module tb_cen_synth;
    import cen_synth_pkg::*;

    localparam int NCH  = 3;
    localparam int HMAX = 12000;

    localparam int K_LK     = 0;
    localparam int K_RD     = 1;
    localparam int K_CE     = 2;
    localparam int K_OC     = 3;
    localparam int K_CNT0   = 4;
    localparam int K_GAPMAX = 5;
    localparam int K_GAPMIN = 6;
    localparam int K_QUIET1 = 7;

    localparam logic [31:0] STEP_26M = 32'd2233382994;

    logic           refclk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_chan;
    logic [31:0]    cfg_step;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] outclk;
    logic           locked;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int kind;
        int a;
        int exp;
    } item_t;

    item_t sb[$];

    logic [NCH-1:0] h_ce [HMAX];
    logic [NCH-1:0] h_oc [HMAX];
    logic           h_lk [HMAX];
    logic           h_rd [HMAX];

    cen_synth #(
        .CHANNELS    (NCH),
        .ACC_W       (32),
        .LOCK_CYCLES (16),
        .INIT_STEP   ({NCH{32'h8000_0000}})
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_step  (cfg_step),
        .ce        (ce),
        .outclk    (outclk),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_LK:     return "locked";
            K_RD:     return "cfg_ready";
            K_CE:     return "ce";
            K_OC:     return "outclk";
            K_CNT0:   return "ce0_count";
            K_GAPMAX: return "ce0_gap_max";
            K_GAPMIN: return "ce0_gap_min";
            K_QUIET1: return "ch1_quiet";
            default:  return "unknown";
        endcase
    endfunction

    task automatic check_item(input item_t it);
        int act;
        int last;
        int gmax;
        int gmin;
        act  = 0;
        last = -1;
        gmax = 0;
        gmin = 1000000;
        case (it.kind)
            K_LK: act = int'(h_lk[it.cyc]);
            K_RD: act = int'(h_rd[it.cyc]);
            K_CE: act = int'(h_ce[it.cyc]);
            K_OC: act = int'(h_oc[it.cyc]);
            K_CNT0: for (int i = it.a; i <= it.cyc; i++) act += int'(h_ce[i][0]);
            K_GAPMAX, K_GAPMIN: begin
                for (int i = it.a; i <= it.cyc; i++) begin
                    if (h_ce[i][0]) begin
                        if (last >= 0) begin
                            if (i - last > gmax) gmax = i - last;
                            if (i - last < gmin) gmin = i - last;
                        end
                        last = i;
                    end
                end
                act = (it.kind == K_GAPMAX) ? gmax : gmin;
            end
            K_QUIET1: for (int i = it.a; i <= it.cyc; i++) act |= int'(h_ce[i][1] | h_oc[i][1]);
            default: act = -1;
        endcase
        checks++;
        if (act != it.exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", kname(it.kind), it.cyc, act, it.exp);
        end
    endtask

    always @(negedge refclk) begin
        if (cyc < HMAX) begin
            h_ce[cyc] = ce;
            h_oc[cyc] = outclk;
            h_lk[cyc] = locked;
            h_rd[cyc] = cfg_ready;
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            check_item(sb.pop_front());
        end
    end

    task automatic expect_at(input int c, input int k, input int v, input int a = 0);
        item_t it;
        it.cyc  = c;
        it.kind = k;
        it.a    = a;
        it.exp  = v;
        sb.push_back(it);
    endtask

    task automatic expect_out(input int c, input logic [NCH-1:0] e_ce, input logic [NCH-1:0] e_oc);
        expect_at(c, K_CE, int'(e_ce));
        expect_at(c, K_OC, int'(e_oc));
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    initial begin
        logic [63:0] step_calc;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_step  = '0;

        step_calc = cen_step(64'd50_000_000, 64'd26_000_000, 32);
        checks++;
        if (step_calc != 64'd2233382994) begin
            errors++;
            $display("FAIL cen_step: got %0d, expected 2233382994", step_calc);
        end

        // Reset, release after edge 2: lock after edge 18, all channels at half rate.
        expect_at(2, K_LK, 0);
        expect_at(2, K_RD, 0);
        expect_out(2, 3'b000, 3'b000);
        expect_at(17, K_LK, 0);
        expect_at(18, K_LK, 1);
        expect_at(18, K_RD, 1);
        expect_out(18, 3'b000, 3'b000);
        expect_out(19, 3'b000, 3'b111);
        expect_out(20, 3'b111, 3'b000);
        expect_out(21, 3'b000, 3'b111);
        expect_out(22, 3'b111, 3'b000);
        wait_cyc(2);
        rst = 1'b0;

        // Channel 1 to quarter rate, accepted on edge 25.
        wait_cyc(24);
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_step = 32'h4000_0000;
        expect_at(25, K_LK, 0);
        expect_at(25, K_RD, 0);
        expect_out(25, 3'b000, 3'b000);
        expect_at(40, K_LK, 0);
        expect_at(41, K_LK, 1);
        expect_out(42, 3'b000, 3'b101);
        expect_out(43, 3'b101, 3'b010);
        expect_out(44, 3'b000, 3'b111);
        expect_out(45, 3'b111, 3'b000);
        expect_out(46, 3'b000, 3'b101);
        expect_out(47, 3'b101, 3'b010);
        expect_out(48, 3'b000, 3'b111);
        expect_out(49, 3'b111, 3'b000);
        wait_cyc(25);
        cfg_valid = 1'b0;

        // Request held through relock: ch2 accepted at 51, ch0 step 0 waits and lands at edge 68.
        wait_cyc(50);
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_step = 32'h8000_0000;
        expect_at(66, K_LK, 0);
        expect_at(67, K_LK, 1);
        expect_at(67, K_RD, 1);
        expect_at(68, K_LK, 0);
        expect_at(83, K_LK, 0);
        expect_at(84, K_LK, 1);
        expect_out(85, 3'b000, 3'b100);
        expect_out(86, 3'b100, 3'b010);
        expect_out(87, 3'b000, 3'b110);
        expect_out(88, 3'b110, 3'b000);
        expect_at(90, K_LK, 1);
        wait_cyc(51);
        cfg_chan = 2'd0; cfg_step = 32'h0000_0000;
        wait_cyc(68);
        cfg_valid = 1'b0;

        // Out-of-range channel: accepted, no relock, phases continue.
        wait_cyc(90);
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_step = 32'h0000_1234;
        expect_at(91, K_LK, 1);
        expect_at(91, K_RD, 1);
        expect_out(91, 3'b000, 3'b110);
        expect_out(92, 3'b110, 3'b000);
        wait_cyc(91);
        cfg_valid = 1'b0;

        // Reset during relock restores INIT_STEP on every channel.
        wait_cyc(95);
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_step = STEP_26M;
        expect_at(96, K_LK, 0);
        expect_at(101, K_LK, 0);
        expect_at(101, K_RD, 0);
        expect_out(101, 3'b000, 3'b000);
        expect_at(116, K_LK, 0);
        expect_at(117, K_LK, 1);
        expect_out(118, 3'b000, 3'b111);
        expect_out(119, 3'b111, 3'b000);
        wait_cyc(96);
        cfg_valid = 1'b0;
        wait_cyc(100);
        rst = 1'b1;
        wait_cyc(101);
        rst = 1'b0;

        // Reset while running.
        wait_cyc(125);
        rst = 1'b1;
        expect_at(126, K_LK, 0);
        expect_at(126, K_RD, 0);
        expect_out(126, 3'b000, 3'b000);
        expect_out(127, 3'b000, 3'b000);
        expect_at(142, K_LK, 0);
        expect_at(143, K_LK, 1);
        expect_out(144, 3'b000, 3'b111);
        wait_cyc(127);
        rst = 1'b0;

        // 50 MHz -> 26 MHz on ch0: 10000 updates (edges 168..10167) give exactly 5200 pulses.
        wait_cyc(150);
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_step = STEP_26M;
        expect_at(167, K_LK, 1);
        expect_at(10167, K_CNT0, 5200, 168);
        expect_at(10167, K_GAPMAX, 2, 168);
        expect_at(10167, K_GAPMIN, 1, 168);
        wait_cyc(151);
        cfg_valid = 1'b0;

        // step 0 stops ch1; ch0 (26 MHz) and ch2 (half rate) restart aligned.
        wait_cyc(10200);
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_step = 32'h0000_0000;
        expect_at(10217, K_LK, 1);
        expect_out(10218, 3'b000, 3'b101);
        expect_out(10219, 3'b101, 3'b000);
        expect_at(10260, K_QUIET1, 0, 10218);
        wait_cyc(10201);
        cfg_valid = 1'b0;

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge refclk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending checks, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cen_synth.md
# cen_synth

Multi-channel fractional clock-enable synthesiser for the system clock tree. From one reference clock it produces CHANNELS independent clock-enable pulse trains and divided square waves at arbitrary rational rates, so that cores no longer need a dedicated hard PLL output per frequency. Each channel's rate can be changed at run time through a valid/ready configuration port, and the block reports a PLL-style `locked` indication. It sits beside the existing PLL wrappers and is driven from one of their outputs.

## Interface
Parameters:
- CHANNELS, 2, number of output channels (1..8)
- ACC_W, 32, phase-accumulator width in bits (16..48)
- LOCK_CYCLES, 16, cycles from reset release or reconfiguration until `locked` rises (≥1)
- INIT_STEP, {CHANNELS{32'h8000_0000}}, flattened per-channel reset step values; channel i occupies bits [i*ACC_W +: ACC_W]

Ports:
- refclk  in  1  the only clock; all logic is clocked on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  block can accept configuration
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel index
- cfg_step  in  ACC_W  new step; output rate = f_refclk × step / 2^ACC_W
- ce  out  CHANNELS  one-cycle clock-enable pulse per channel
- outclk  out  CHANNELS  accumulator MSB per channel (≈50 % duty divided clock)
- locked  out  1  all channels running with current configuration

## Operation
- Reset: every step register is loaded from INIT_STEP, accumulators are cleared, and the lock counter is loaded with LOCK_CYCLES. Outputs: ce=0, outclk=0, locked=0, cfg_ready=0.
- Settling: while locked=0, the lock counter decrements once per cycle and the accumulators are held at 0. When the counter reaches 0, locked=1 and cfg_ready=1.
- Running (locked=1), per channel on every edge:
  - {carry, acc} ← acc + step, computed in ACC_W+1 bits.
  - ce ← carry.
  - outclk ← MSB of the new acc.
- step=0 stops the channel: ce and outclk stay 0. Wrap-around of acc is modulo 2^ACC_W with no saturation.
- Configuration is accepted on an edge where cfg_valid & cfg_ready. On that edge:
  - step[cfg_chan] ← cfg_step.
  - All accumulators, ce and outclk are cleared.
  - locked and cfg_ready go to 0.
  - The lock counter reloads LOCK_CYCLES.
  - Clearing all accumulators re-aligns every channel to a common phase.
- cfg_chan ≥ CHANNELS: the request is accepted and ignored. No step changes and no relock occurs.
- cfg_valid while cfg_ready=0: not accepted. The requester must hold cfg_valid with stable cfg_chan and cfg_step until the handshake completes.
- rst asserted mid-operation (including mid-relock) overrides everything on the same edge.

## Timing
- Registered outputs only; no combinational path from input to output.
- locked rises exactly LOCK_CYCLES edges after the first edge with rst=0, or after the accepting edge of a configuration.
- First accumulator update happens on the first edge with locked=1. With step=2^(ACC_W-1), ce is first high 2 cycles after locked rises and then every 2nd cycle.
- ce pulse width is exactly 1 cycle. Pulse count over any 2^ACC_W/gcd window is exact, and pulse-to-pulse jitter is ≤1 refclk cycle.
- cfg throughput: one configuration per LOCK_CYCLES+1 cycles.

## Structure
- Shared package `cen_synth_pkg` holds:
  - the default ACC_W constant;
  - a constant function `cen_step(f_ref_hz, f_out_hz, acc_w)` returning round(f_out × 2^acc_w / f_ref), used by top levels to build INIT_STEP. For example, 50 MHz → 26 MHz at ACC_W=32 gives 32'd2233382994.
- Sub-module `cen_nco`: one channel, containing the accumulator, carry, ce and outclk registers, with ports clear, run and step. It is instantiated CHANNELS times by a generate loop. The top level holds the lock counter, step registers and handshake.

## Test plan
- Reset with defaults (LOCK_CYCLES=16, step 0x8000_0000) → locked=0 for 16 cycles then 1. ce toggles 0,1,0,1 starting 2 cycles after locked rises. outclk has period 2.
- cfg_step=0x4000_0000 on channel 1 → locked low for 16 cycles. Channel 1 then emits ce every 4 cycles and outclk has 2 high / 2 low. Channel 0 is unchanged in rate and phase-aligned with channel 1.
- Step 2233382994, 10 000 running cycles → exactly 5200 ce pulses (±1). Pulse gaps are only 1 or 2 cycles.
- cfg_valid held during relock → not accepted until cfg_ready=1, then accepted exactly once.
- cfg_step=0 → ce and outclk stay 0. cfg_chan=CHANNELS → no relock and all steps unchanged.
- rst pulsed mid-relock and mid-run → all outputs 0 on the next cycle, INIT_STEP restored, locked returns after LOCK_CYCLES.
